// File: rtl/ram_delay_line_dual_tap_ram.sv
// dual_tap_ram: small RAM with one write port and two registered read ports.
//
// Ports:
//   clk_i               clock, all updates on rising edge
//   rst_i               synchronous active-high reset; clears every word and both outputs
//   we_i/waddr_i/wdata_i   write port
//   re_a_i/raddr_a_i    read port A enable/address, result registered into q_a_o
//   re_b_i/raddr_b_i    read port B enable/address, result registered into q_b_o
//
// A read that hits the address being written in the same edge returns the
// new write data (write-first). Reading the array as a flop bank keeps the
// reset-clear of contents possible.
module dual_tap_ram #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 13,
    parameter int AW_P    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [AW_P-1:0]    waddr_i,
    input  logic [WIDTH_P-1:0] wdata_i,
    input  logic               re_a_i,
    input  logic [AW_P-1:0]    raddr_a_i,
    input  logic               re_b_i,
    input  logic [AW_P-1:0]    raddr_b_i,
    output logic [WIDTH_P-1:0] q_a_o,
    output logic [WIDTH_P-1:0] q_b_o
);

    logic [WIDTH_P-1:0] mem [DEPTH_P];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH_P; i++) mem[i] <= '0;
            q_a_o <= '0;
            q_b_o <= '0;
        end else begin
            if (we_i) mem[waddr_i] <= wdata_i;
            if (re_a_i) q_a_o <= (we_i && waddr_i == raddr_a_i) ? wdata_i : mem[raddr_a_i];
            if (re_b_i) q_b_o <= (we_i && waddr_i == raddr_b_i) ? wdata_i : mem[raddr_b_i];
        end
    end

endmodule

// File: rtl/ram_delay_line.sv
// ram_delay_line: two-tap delay line over a circular RAM, delay counted in
// accepted samples, with a one-entry elastic output stage.
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset (wins over a simultaneous accept)
//   valid_i   upstream sample valid
//   ready_o   block can accept (output register empty or being drained)
//   data_i    input sample
//   valid_o   tap outputs valid
//   ready_i   downstream ready
//   data_a_o  sample delayed by DELAY_A_P accepts
//   data_b_o  sample delayed by DELAY_B_P accepts
module ram_delay_line #(
    parameter int WIDTH_P   = 8,
    parameter int DELAY_P   = 12,
    parameter int DELAY_A_P = DELAY_P,
    parameter int DELAY_B_P = DELAY_P
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] data_a_o,
    output logic [WIDTH_P-1:0] data_b_o
);

    localparam int DEPTH = DELAY_P + 1;
    localparam int PW    = (DELAY_P > 0) ? $clog2(DEPTH) : 1;

    // Read pointers start DELAY_X_P slots behind the write pointer so the
    // first DELAY_X_P reads return the reset-cleared words.
    localparam logic [PW-1:0] RA_RST = (DELAY_A_P == 0) ? '0 : PW'(DEPTH - DELAY_A_P);
    localparam logic [PW-1:0] RB_RST = (DELAY_B_P == 0) ? '0 : PW'(DEPTH - DELAY_B_P);

    generate
        if (DELAY_A_P > DELAY_P || DELAY_B_P > DELAY_P) begin : g_bad_delay
            $fatal(1, "ram_delay_line: tap delay exceeds DELAY_P");
        end
    endgenerate

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DELAY_P)) ? '0 : p + 1'b1;
    endfunction

    logic          fire;
    logic [PW-1:0] wr_ptr, ra_ptr, rb_ptr;

    assign ready_o = ~valid_o | ready_i;
    assign fire    = valid_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            ra_ptr  <= RA_RST;
            rb_ptr  <= RB_RST;
            valid_o <= 1'b0;
        end else if (fire) begin
            wr_ptr  <= bump(wr_ptr);
            ra_ptr  <= bump(ra_ptr);
            rb_ptr  <= bump(rb_ptr);
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // Taps are the RAM read registers themselves; enabling them only on fire
    // makes them hold through stalls and gaps.
    dual_tap_ram #(
        .WIDTH_P (WIDTH_P),
        .DEPTH_P (DEPTH),
        .AW_P    (PW)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (fire),
        .waddr_i   (wr_ptr),
        .wdata_i   (data_i),
        .re_a_i    (fire),
        .raddr_a_i (ra_ptr),
        .re_b_i    (fire),
        .raddr_b_i (rb_ptr),
        .q_a_o     (data_a_o),
        .q_b_o     (data_b_o)
    );

endmodule

// File: tb/tb_ram_delay_line.sv
module tb_ram_delay_line;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] data = '0;

    // u0: defaults (12/12), u1: A=0 B=3, u2: DELAY_P=3 (both taps 3)
    logic       rdy0, rdy1, rdy2, vo0, vo1, vo2;
    logic [7:0] a0, b0, a1, b1, a2, b2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_delay_line u0 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rdy0), .data_i(data),
        .valid_o(vo0), .ready_i(ready), .data_a_o(a0), .data_b_o(b0));

    ram_delay_line #(.DELAY_A_P(0), .DELAY_B_P(3)) u1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rdy1), .data_i(data),
        .valid_o(vo1), .ready_i(ready), .data_a_o(a1), .data_b_o(b1));

    ram_delay_line #(.DELAY_P(3)) u2 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rdy2), .data_i(data),
        .valid_o(vo2), .ready_i(ready), .data_a_o(a2), .data_b_o(b2));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, then settle 1 time unit past the rising edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rd);
        @(negedge clk);
        rst = r; valid = v; data = d; ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state
        step(1'b1, 1'b0, 8'd0, 1'b1);
        chk("rst_vo0", 8'(vo0), 8'd0);
        chk("rst_a0", a0, 8'd0);
        chk("rst_b0", b0, 8'd0);
        chk("rst_vo2", 8'(vo2), 8'd0);
        chk("rst_rdy0", 8'(rdy0), 8'd1);

        // ---------------- continuous stream 1..20, all DUTs
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 8'(k), 1'b1);
            chk($sformatf("s_vo0_%0d", k), 8'(vo0), 8'd1);
            chk($sformatf("s_a0_%0d", k), a0, (k > 12) ? 8'(k - 12) : 8'd0);
            chk($sformatf("s_b0_%0d", k), b0, (k > 12) ? 8'(k - 12) : 8'd0);
            chk($sformatf("s_a1_%0d", k), a1, 8'(k));
            chk($sformatf("s_b1_%0d", k), b1, (k > 3) ? 8'(k - 3) : 8'd0);
            chk($sformatf("s_a2_%0d", k), a2, (k > 3) ? 8'(k - 3) : 8'd0);
            chk($sformatf("s_b2_%0d", k), b2, (k > 3) ? 8'(k - 3) : 8'd0);
        end

        // ---------------- A=0 / B=3 with data 10..50
        step(1'b1, 1'b0, 8'd0, 1'b1);
        chk("r2_a1", a1, 8'd0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 8'(10 * k), 1'b1);
            chk($sformatf("z_a1_%0d", k), a1, 8'(10 * k));
            chk($sformatf("z_b1_%0d", k), b1, (k > 3) ? 8'(10 * (k - 3)) : 8'd0);
        end

        // ---------------- backpressure on u2
        step(1'b1, 1'b0, 8'd0, 1'b1);
        for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 8'(k), 1'b1);
        chk("bp_pre_a2", a2, 8'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            valid = 1'b1; data = 8'd99; ready = 1'b0;
            #1;
            chk($sformatf("bp_rdy2_%0d", c), 8'(rdy2), 8'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp_vo2_%0d", c), 8'(vo2), 8'd1);
            chk($sformatf("bp_a2_%0d", c), a2, 8'd1);
            chk($sformatf("bp_b2_%0d", c), b2, 8'd1);
        end
        @(negedge clk);
        ready = 1'b1; data = 8'd5;
        #1;
        chk("bp_rdy2_resume", 8'(rdy2), 8'd1);
        @(posedge clk);
        #1;
        chk("bp_a2_5", a2, 8'd2);
        for (int k = 6; k <= 8; k++) begin
            step(1'b0, 1'b1, 8'(k), 1'b1);
            chk($sformatf("bp_a2_%0d", k), a2, 8'(k - 3));
        end

        // ---------------- valid gaps on u2
        step(1'b1, 1'b0, 8'd0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b1, 8'(k), 1'b1);
            chk($sformatf("g_vo2_on_%0d", k), 8'(vo2), 8'd1);
            chk($sformatf("g_a2_on_%0d", k), a2, (k > 3) ? 8'(k - 3) : 8'd0);
            step(1'b0, 1'b0, 8'd77, 1'b1);
            chk($sformatf("g_vo2_off_%0d", k), 8'(vo2), 8'd0);
            chk($sformatf("g_a2_off_%0d", k), a2, (k > 3) ? 8'(k - 3) : 8'd0);
        end

        // ---------------- mid-stream reset beats a simultaneous accept
        for (int k = 7; k <= 9; k++) step(1'b0, 1'b1, 8'(k), 1'b1);
        chk("mr_pre_a2", a2, 8'd6);
        step(1'b1, 1'b1, 8'd55, 1'b1);
        chk("mr_vo2", 8'(vo2), 8'd0);
        chk("mr_a2", a2, 8'd0);
        chk("mr_a1", a1, 8'd0);
        chk("mr_a0", a0, 8'd0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 8'(20 + k), 1'b1);
            chk($sformatf("mr_a2_%0d", k), a2, (k > 3) ? 8'(20 + k - 3) : 8'd0);
            chk($sformatf("mr_b1_%0d", k), b1, (k > 3) ? 8'(20 + k - 3) : 8'd0);
            chk($sformatf("mr_a0_%0d", k), a0, 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_delay_line.md
RAM_DELAY_LINE -- requirements
Module: ram_delay_line

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8, data width in bits.
REQ-002 SHALL have parameter DELAY_P, default 12, maximum delay in accepted samples; RAM depth is DELAY_P+1.
REQ-003 SHALL have parameter DELAY_A_P, default DELAY_P, delay of tap A in accepted samples.
REQ-004 SHALL have parameter DELAY_B_P, default DELAY_P, delay of tap B in accepted samples.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have port valid_i, input, 1 bit, upstream sample valid.
REQ-008 SHALL have port ready_o, output, 1 bit, block can accept a sample.
REQ-009 SHALL have port data_i, input, WIDTH_P bits, input sample.
REQ-010 SHALL have port valid_o, output, 1 bit, tap outputs valid.
REQ-011 SHALL have port ready_i, input, 1 bit, downstream ready.
REQ-012 SHALL have port data_a_o, output, WIDTH_P bits, tap A sample.
REQ-013 SHALL have port data_b_o, output, WIDTH_P bits, tap B sample.

Function
REQ-014 SHALL stop elaboration with a fatal error if DELAY_A_P > DELAY_P or DELAY_B_P > DELAY_P.
REQ-015 SHALL define an accept ("fire") as valid_i & ready_o in a cycle; all pointer, RAM and tap updates occur only on fire.
REQ-016 SHALL drive ready_o = ~valid_o | ready_i (combinational; one-entry elastic stage).
REQ-017 SHALL set valid_o to 1 on fire; clear it to 0 when ready_i=1 and no fire; otherwise hold it.
REQ-018 SHALL keep a write pointer, width clog2(DELAY_P+1), incrementing on fire and wrapping DELAY_P -> 0.
REQ-019 SHALL keep read pointers A and B with the same width and wrap rule, incrementing on fire.
REQ-020 SHALL reset read pointer X to 0 when DELAY_X_P = 0, else to DELAY_P+1-DELAY_X_P; pointer X therefore always equals write pointer minus DELAY_X_P (mod DELAY_P+1).
REQ-021 SHALL on fire write data_i to RAM[write pointer] and register RAM[read pointer A] into data_a_o and RAM[read pointer B] into data_b_o in the same edge.
REQ-022 SHALL resolve a same-address read/write collision write-first: the tap receives the data_i being written.
REQ-023 SHALL result in: on the edge of the k-th fire, data_X_o becomes the sample accepted on fire k-DELAY_X_P (the current data_i when DELAY_X_P=0); it updates in the same edge as valid_o rises.
REQ-024 SHALL hold data_a_o, data_b_o and all pointers unchanged in cycles without fire, including stalls with valid_o=1 and ready_i=0.
REQ-025 SHALL output 0 on tap X for the first DELAY_X_P fires after reset (RAM reset contents).

Reset
REQ-026 SHALL on rst_i=1 at a clock edge set valid_o=0, data_a_o=0, data_b_o=0, all RAM words 0, write pointer 0, read pointers per REQ-020.
REQ-027 SHALL give rst_i priority over a simultaneous fire; a reset mid-stream discards all stored history.

Structure
REQ-028 SHALL need no shared package; pointer width is a local constant clog2(DELAY_P+1).
REQ-029 SHALL place the RAM in one sub-module, dual_tap_ram: one write port, two registered read ports with enables, write-first collision, synchronous reset of contents and outputs.

Verification
REQ-030 SHALL cover: defaults, continuous valid_i=1, ready_i=1, data_i=1,2,3,... -> data_a_o=data_b_o=0 for first 12 accepts, then 1 on accept 13, 2 on accept 14.
REQ-031 SHALL cover: DELAY_A_P=0, DELAY_B_P=3, data 10,20,30,40,50 -> A follows 10,20,30,40,50 and B follows 0,0,0,10,20.
REQ-032 SHALL cover: backpressure, valid_o=1 with ready_i=0 -> ready_o=0, input ignored, taps hold; ready_i=1 resumes with no lost or duplicated sample.
REQ-033 SHALL cover: gaps in valid_i (valid toggling 1/0) -> delay counted in accepts, not cycles; valid_o drops after drain.
REQ-034 SHALL cover: wrap, DELAY_P=3, 20 continuous accepts -> tap A lags exactly 3 samples across pointer wraps.
REQ-035 SHALL cover: rst_i asserted mid-stream -> next cycle valid_o=0 and taps 0; restart replays zeros for DELAY_X_P accepts.
